// File: rtl/id_ex_stage.sv
// id_ex_stage: register file read in ID plus the ID/EX pipeline register with load-use detection.
//   Ports: clk, reset (async, active-high); id_valid, pc_id, inst_id = ID instruction;
//   flush/stall = EX register control; wb_en, wb_rd, wb_data = register-file write port;
//   ex_valid, pc_ex, inst_ex, rs1_ex, rs2_ex, rd_ex = EX register; hazard_stall = load-use stall to IF/ID.
//   Optional macro ID_WB_BYPASS_EN: a same-cycle writeback is forwarded to the ID read ports.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [XLEN-1:0]          pc_id,
  input  logic [31:0]              inst_id,
  input  logic                     flush,
  input  logic                     stall,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     ex_valid,
  output logic [XLEN-1:0]          pc_ex,
  output logic [XLEN-1:0]          rs1_ex,
  output logic [XLEN-1:0]          rs2_ex,
  output logic [31:0]              inst_ex,
  output logic [$clog2(NREGS)-1:0] rd_ex,
  output logic                     hazard_stall
);
  localparam int AW = $clog2(NREGS);
  logic [XLEN-1:0] regs [NREGS];
  logic [AW-1:0]   rs1_idx, rs2_idx;
  logic [XLEN-1:0] rd1, rd2;
  logic            wr;
  assign rs1_idx = inst_id[15 +: AW];
  assign rs2_idx = inst_id[20 +: AW];
  assign wr      = wb_en && wb_rd != '0;
  // Entry 0 is cleared by reset and never written, so it always reads zero.
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (wr)
      regs[wb_rd] <= wb_data;
`ifdef ID_WB_BYPASS_EN
  assign rd1 = (wr && wb_rd == rs1_idx) ? wb_data : regs[rs1_idx];
  assign rd2 = (wr && wb_rd == rs2_idx) ? wb_data : regs[rs2_idx];
`else
  assign rd1 = regs[rs1_idx];
  assign rd2 = regs[rs2_idx];
`endif
  // A load in EX cannot forward to the instruction behind it; hold ID one cycle.
  assign hazard_stall = ex_valid && inst_ex[6:0] == 7'b0000011 && rd_ex != '0 && id_valid &&
                        (rd_ex == rs1_idx || rd_ex == rs2_idx);
  always_ff @(posedge clk or posedge reset)
    if (reset || flush || (!stall && hazard_stall)) begin
      ex_valid <= 1'b0;
      pc_ex    <= '0;
      inst_ex  <= '0;
      rs1_ex   <= '0;
      rs2_ex   <= '0;
      rd_ex    <= '0;
    end else if (!stall) begin
      ex_valid <= id_valid;
      pc_ex    <= id_valid ? pc_id : '0;
      inst_ex  <= id_valid ? inst_id : '0;
      rs1_ex   <= id_valid ? rd1 : '0;
      rs2_ex   <= id_valid ? rd2 : '0;
      rd_ex    <= id_valid ? inst_id[7 +: AW] : '0;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for id_ex_stage (default and 64-bit/16-register builds).
module tb_id_ex_stage;
  logic        clk = 1'b0, reset = 1'b1;
  logic        id_valid = 0, flush = 0, stall = 0, wb_en = 0;
  logic [31:0] pc_id = 0, inst_id = 0, wb_data = 0;
  logic [4:0]  wb_rd = 0;
  logic        ex_valid, hazard_stall;
  logic [31:0] pc_ex, rs1_ex, rs2_ex, inst_ex;
  logic [4:0]  rd_ex;
  logic        id_valid2 = 0, wb_en2 = 0;
  logic [63:0] pc_id2 = 0, wb_data2 = 0;
  logic [31:0] inst_id2 = 0;
  logic [3:0]  wb_rd2 = 0;
  logic        ex_valid2, hazard_stall2;
  logic [63:0] pc_ex2, rs1_ex2, rs2_ex2;
  logic [31:0] inst_ex2;
  logic [3:0]  rd_ex2;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic v; logic [31:0] pc, inst, rs1, rs2; logic [4:0] rd;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .pc_id(pc_id), .inst_id(inst_id),
    .flush(flush), .stall(stall), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .pc_ex(pc_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .inst_ex(inst_ex), .rd_ex(rd_ex), .hazard_stall(hazard_stall));
  id_ex_stage #(.XLEN(64), .NREGS(16)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid2), .pc_id(pc_id2), .inst_id(inst_id2),
    .flush(1'b0), .stall(1'b0), .wb_en(wb_en2), .wb_rd(wb_rd2), .wb_data(wb_data2),
    .ex_valid(ex_valid2), .pc_ex(pc_ex2), .rs1_ex(rs1_ex2), .rs2_ex(rs2_ex2),
    .inst_ex(inst_ex2), .rd_ex(rd_ex2), .hazard_stall(hazard_stall2));
  function automatic logic [31:0] add_i(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] lw_i(input logic [4:0] rd, rs1);
    return {12'b0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic v, input logic [31:0] pc, inst, rs1, rs2);
    id_valid = v;
    pc_id = pc;
    inst_id = inst;
    q.push_back('{v, v ? pc : 32'h0, v ? inst : 32'h0, v ? rs1 : 32'h0, v ? rs2 : 32'h0,
                  v ? inst[11:7] : 5'h0});
  endtask
  task automatic bubble();
    q.push_back('{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0});
  endtask
  task automatic check_ex(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = q.pop_front();
    chk({tag, "_valid"}, ex_valid, e.v);
    chk({tag, "_pc"}, pc_ex, e.pc);
    chk({tag, "_inst"}, inst_ex, e.inst);
    chk({tag, "_rs1"}, rs1_ex, e.rs1);
    chk({tag, "_rs2"}, rs2_ex, e.rs2);
    chk({tag, "_rd"}, rd_ex, e.rd);
  endtask
  task automatic wr(input logic [4:0] rd, input logic [31:0] d);
    wb_en = 1;
    wb_rd = rd;
    wb_data = d;
    tick();
    wb_en = 0;
  endtask
  initial begin
    logic [4:0]  r5;
    logic [31:0] byp;
    #2;
    bubble();
    check_ex("reset");
    chk("reset_hazard", hazard_stall, 1'b0);
    #10 reset = 0;
    tick();
    wr(5'd1, 32'd7);
    wr(5'd2, 32'd9);
    wr(5'd4, 32'h44);
    issue(1, 32'h100, add_i(5'd3, 5'd1, 5'd2), 32'd7, 32'd9);
    #1 chk("normal_no_hazard", hazard_stall, 1'b0);
    tick();
    check_ex("normal");
    issue(1, 32'h104, lw_i(5'd4, 5'd1), 32'd7, 32'd0);
    tick();
    check_ex("load");
    id_valid = 1;
    pc_id = 32'h108;
    inst_id = add_i(5'd6, 5'd4, 5'd1);
    #1 chk("loaduse_hazard", hazard_stall, 1'b1);
    bubble();
    tick();
    check_ex("loaduse_bubble");
    chk("loaduse_hazard_drops", hazard_stall, 1'b0);
    issue(1, 32'h108, add_i(5'd6, 5'd4, 5'd1), 32'h44, 32'd7);
    tick();
    check_ex("loaduse_add");
    issue(1, 32'h10c, lw_i(5'd0, 5'd1), 32'd7, 32'd0);
    tick();
    check_ex("load_x0");
    issue(1, 32'h110, add_i(5'd7, 5'd0, 5'd1), 32'd0, 32'd7);
    #1 chk("load_x0_no_hazard", hazard_stall, 1'b0);
    tick();
    check_ex("after_load_x0");
    flush = 1;
    stall = 1;
    id_valid = 1;
    pc_id = 32'h114;
    inst_id = add_i(5'd3, 5'd1, 5'd2);
    bubble();
    tick();
    check_ex("flush_over_stall");
    flush = 0;
    stall = 0;
    issue(1, 32'h200, add_i(5'd3, 5'd1, 5'd2), 32'd7, 32'd9);
    tick();
    check_ex("pre_stall");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_valid = 1;
      pc_id = 32'h300 + i;
      inst_id = add_i(5'd9, 5'd2, 5'd4);
      q.push_back('{1'b1, 32'h200, add_i(5'd3, 5'd1, 5'd2), 32'd7, 32'd9, 5'd3});
      tick();
      check_ex($sformatf("stall_hold%0d", i));
    end
    stall = 0;
    issue(0, 32'h400, add_i(5'd3, 5'd1, 5'd2), 32'd0, 32'd0);
    tick();
    check_ex("id_invalid");
    wr(5'd1, 32'h11);
`ifdef ID_WB_BYPASS_EN
    byp = 32'h55;
`else
    byp = 32'h11;
`endif
    issue(1, 32'h500, add_i(5'd8, 5'd1, 5'd2), byp, 32'd9);
    wb_en = 1;
    wb_rd = 5'd1;
    wb_data = 32'h55;
    tick();
    wb_en = 0;
    check_ex("bypass");
    issue(1, 32'h504, add_i(5'd9, 5'd1, 5'd2), 32'h55, 32'd9);
    tick();
    check_ex("after_write");
    issue(1, 32'h508, add_i(5'd10, 5'd0, 5'd0), 32'd0, 32'd0);
    wb_en = 1;
    wb_rd = 5'd0;
    wb_data = 32'hFF;
    tick();
    wb_en = 0;
    check_ex("x0_write_cycle");
    issue(1, 32'h50c, add_i(5'd10, 5'd0, 5'd0), 32'd0, 32'd0);
    tick();
    check_ex("x0_read");
    wr(5'd5, 32'hA5A5A5A5);
    issue(1, 32'h600, add_i(5'd11, 5'd5, 5'd0), 32'hA5A5A5A5, 32'd0);
    tick();
    check_ex("x5_read");
    #2 reset = 1;
    #1;
    bubble();
    check_ex("async_reset");
    chk("async_reset_hazard", hazard_stall, 1'b0);
    reset = 0;
    issue(1, 32'h600, add_i(5'd11, 5'd5, 5'd0), 32'd0, 32'd0);
    tick();
    check_ex("x5_after_reset");
    id_valid = 0;
    r5 = 5'b10101;
    wb_en2 = 1;
    wb_rd2 = r5[3:0];
    wb_data2 = 64'hDEADBEEF01234567;
    tick();
    wb_rd2 = 4'd0;
    wb_data2 = 64'hFF;
    id_valid2 = 1;
    pc_id2 = 64'h1_0000_0000;
    inst_id2 = add_i(5'b10110, 5'b10101, 5'd0);
    tick();
    wb_en2 = 0;
    chk("w64_valid", ex_valid2, 1'b1);
    chk("w64_pc", pc_ex2, 64'h1_0000_0000);
    chk("w64_rs1_x5", rs1_ex2, 64'hDEADBEEF01234567);
    chk("w64_rs2_x0", rs2_ex2, 64'd0);
    chk("w64_rd", rd_ex2, 4'd6);
    inst_id2 = add_i(5'd2, 5'd0, 5'd16);
    tick();
    chk("w64_x0_read", rs1_ex2, 64'd0);
    chk("w64_x16_alias_x0", rs2_ex2, 64'd0);
    id_valid2 = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
